keystone_coeff_sequencer: RTL and testbench
===========================================

// Module: keystone_coeff_sequencer
// PURPOSE
//  Owns the 9 homography coefficients (H11..H33) driven into Keystone_Correction.
//  Software writes a shadow bank; on commit the block waits for the next start-of-frame
//  beat and stalls the input stream. It then drains the correction pipeline and swaps the
//  shadow bank into the active bank, so every frame is processed with one consistent set.
//  Sits between upstream AXI-stream source and Keystone_Correction input; snoops IP output handshake.
// PARAMETERS
//  FRAC_BITS     23    coefficient fraction bits; identity value = 1<<FRAC_BITS
//  MAX_INFLIGHT  4095  max beats inside IP pipeline; inflight counter width = $clog2(MAX_INFLIGHT+1)
//  SWAP_CNT_W    16    width of swap_count
// PORTS
//  clock          in   1   sole clock
//  reset          in   1   synchronous, active-high
//  cfg_valid      in   1   coefficient write request
//  cfg_ready      out  1   write accepted when cfg_valid&cfg_ready
//  cfg_addr       in   4   0..8 = H11,H12,H13,H21,H22,H23,H31,H32,H33 (row-major)
//  cfg_data       in   32  coefficient value
//  cfg_commit     in   1   single-cycle request to apply shadow bank at next frame
//  cfg_err        out  1   1-cycle pulse: accepted write with cfg_addr>8 (write dropped)
//  up_valid_in    in   1   upstream beat valid
//  up_sof_in      in   1   upstream start-of-frame (tuser)
//  up_ready_out   out  1   ready to upstream
//  ip_valid_out   out  1   valid into IP valid_in
//  ip_ready_in    in   1   IP ready_out
//  ip_out_valid   in   1   IP valid_out (snooped)
//  ds_ready_in    in   1   downstream ready into IP ready_in (snooped)
//  h11..h33       out  32  active coefficients (9 ports), registered
//  busy           out  1   state != IDLE
//  swap_count     out  SWAP_CNT_W  number of completed swaps, wraps
// BEHAVIOUR
//  Reset: state=IDLE; shadow=active=identity (h11=h22=h33=1<<FRAC_BITS, others 0);
//   inflight=0, swap_count=0, cfg_err=0. cfg_ready=1, busy=0.
//  Pass-through (IDLE, ARMED): ip_valid_out=up_valid_in, up_ready_out=ip_ready_in.
//  Gated (DRAIN, SWAP): ip_valid_out=0, up_ready_out=0.
//  ARMED also gates the SOF beat combinationally: ip_valid_out = up_valid_in & ~up_sof_in,
//   up_ready_out = ip_ready_in & ~up_sof_in.
//  FSM:
//   IDLE : cfg_ready=1. A write updates shadow[addr] next cycle.
//          cfg_commit -> ARMED. Write+commit in same cycle: write lands, then is committed.
//   ARMED: cfg_ready=0; commit ignored. up_valid_in&up_sof_in -> DRAIN (beat not consumed).
//   DRAIN: cfg_ready=0. inflight==0 -> SWAP. Also taken if inflight already 0 on entry.
//   SWAP : one cycle. active<=shadow; swap_count++ (wrap). -> IDLE.
//          The held SOF beat is forwarded in IDLE with the new coefficients visible.
//  h* outputs change only on the clock edge that ends SWAP; never mid-frame.
//  inflight: +1 on ip_valid_out&ip_ready_in; -1 on ip_out_valid&ds_ready_in.
//   Both in the same cycle: unchanged. Never underflows: decrement at 0 is ignored.
//   Saturates at MAX_INFLIGHT; overflow is an assertion failure in simulation.
//  Latency: ARMED->first new-coeff beat = drain time + 2 cycles (DRAIN, SWAP).
//   Pass-through paths are zero-latency combinational; no data is buffered.
//  reset mid-operation: pending commit and shadow edits are lost; active returns to identity.
//  The block never drops or duplicates stream beats; data/tlast wires bypass it.
// STRUCTURE
//  Package keystone_cfg_pkg:
//   - coeff_t (logic [31:0])
//   - coeff_idx_e (H11..H33 = 0..8)
//   - NUM_COEFFS=9
//   - seq_state_e {IDLE,ARMED,DRAIN,SWAP}
//   - function identity_coeff(frac_bits)
//  Sub-module keystone_inflight_counter: inc/dec strobes, count, is_zero, saturation.
//  Shadow/active banks as coeff_t [NUM_COEFFS] arrays.
// TESTING
//  1 Reset, no writes -> h11=h22=h33=8388608, others 0, busy=0, swap_count=0.
//  2 Write H13=2, H32=608, commit; no SOF for 50 cycles.
//    -> h13 stays 0, busy=1, cfg_ready=0, stream passes.
//  3 From 2: send 5 beats (IP stalls output, inflight=5), then SOF beat.
//    -> up_ready_out=0 while inflight drains; swap 2 cycles after inflight hits 0.
//    -> h13=2, h32=608 before SOF beat forwarded; swap_count=1.
//  4 Write cfg_addr=12 -> cfg_err pulses 1 cycle, shadow unchanged.
//    Write+commit same cycle in IDLE -> value committed.
//  5 Simultaneous in/out handshakes at inflight=3 for 10 cycles -> inflight stays 3.
//  6 Reset asserted in DRAIN -> next cycle IDLE, identity coeffs, up_ready_out follows ip_ready_in.

Source files
------------

// File: rtl/keystone_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keystone_cfg_pkg
//  Purpose  : Shared types and helpers for the keystone coefficient sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package keystone_cfg_pkg;

    typedef logic [31:0] coeff_t;

    localparam int NUM_COEFFS = 9;

    // Row-major order of the 3x3 homography matrix.
    typedef enum logic [3:0] {
        H11 = 4'd0,
        H12 = 4'd1,
        H13 = 4'd2,
        H21 = 4'd3,
        H22 = 4'd4,
        H23 = 4'd5,
        H31 = 4'd6,
        H32 = 4'd7,
        H33 = 4'd8
    } coeff_idx_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } seq_state_e;

    function automatic coeff_t identity_coeff(input int frac_bits);
        return coeff_t'(1) << frac_bits;
    endfunction

    // Entry of the identity matrix at a row-major position.
    function automatic coeff_t identity_entry(input int idx, input int frac_bits);
        return ((idx / 3) == (idx % 3)) ? identity_coeff(frac_bits) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keystone_inflight_counter.sv
`default_nettype none
// ============================================================================
//  Module   : keystone_inflight_counter
//  Purpose  : Occupancy counter for beats inside the correction pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module keystone_inflight_counter #(
    parameter int MAX_COUNT = 4095,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_is_zero
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Simultaneous inc/dec cancel; decrement at zero and increment at max are dropped.
    always_comb begin
        w_count_next = r_count;
        if (i_inc && !i_dec) begin
            if (r_count != c_max) begin
                w_count_next = r_count + CNT_W'(1);
            end
        end else if (!i_inc && i_dec) begin
            if (r_count != '0) begin
                w_count_next = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_is_zero = (r_count == '0);

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_inc && !i_dec && (r_count == c_max)));

endmodule
`default_nettype wire

// File: rtl/keystone_coeff_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : keystone_coeff_sequencer
//  Purpose  : Shadow/active homography coefficient banks, swapped only at a
//             frame boundary after the correction pipeline has drained.
//  Revision : 1.0 - initial release
// ============================================================================
module keystone_coeff_sequencer
    import keystone_cfg_pkg::*;
#(
    parameter int FRAC_BITS    = 23,
    parameter int MAX_INFLIGHT = 4095,
    parameter int SWAP_CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_addr,
    input  logic [31:0]           cfg_data,
    input  logic                  cfg_commit,
    output logic                  cfg_err,
    input  logic                  up_valid_in,
    input  logic                  up_sof_in,
    output logic                  up_ready_out,
    output logic                  ip_valid_out,
    input  logic                  ip_ready_in,
    input  logic                  ip_out_valid,
    input  logic                  ds_ready_in,
    output logic [31:0]           h11,
    output logic [31:0]           h12,
    output logic [31:0]           h13,
    output logic [31:0]           h21,
    output logic [31:0]           h22,
    output logic [31:0]           h23,
    output logic [31:0]           h31,
    output logic [31:0]           h32,
    output logic [31:0]           h33,
    output logic                  busy,
    output logic [SWAP_CNT_W-1:0] swap_count
);

    localparam int         c_cnt_w    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [3:0] c_max_addr = 4'(NUM_COEFFS - 1);

    seq_state_e            r_state;
    seq_state_e            w_state_next;
    coeff_t                r_shadow [NUM_COEFFS];
    coeff_t                r_active [NUM_COEFFS];
    logic                  r_cfg_err;
    logic [SWAP_CNT_W-1:0] r_swap_count;

    logic w_cfg_accept;
    logic w_addr_ok;
    logic w_inc;
    logic w_dec;
    logic w_inflight_zero;

    assign w_cfg_accept = cfg_valid & cfg_ready;
    assign w_addr_ok    = (cfg_addr <= c_max_addr);
    assign w_inc        = ip_valid_out & ip_ready_in;
    assign w_dec        = ip_out_valid & ds_ready_in;

    keystone_inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CNT_W     (c_cnt_w)
    ) u_inflight (
        .clk       (clock),
        .rst       (reset),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .o_is_zero (w_inflight_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ARMED holds back only the SOF beat so the old frame can finish with old coefficients.
    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        ip_valid_out = 1'b0;
        up_ready_out = 1'b0;
        case (r_state)
            IDLE: begin
                cfg_ready    = 1'b1;
                ip_valid_out = up_valid_in;
                up_ready_out = ip_ready_in;
                if (cfg_commit) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                ip_valid_out = up_valid_in & ~up_sof_in;
                up_ready_out = ip_ready_in & ~up_sof_in;
                if (up_valid_in && up_sof_in) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_inflight_zero) begin
                    w_state_next = SWAP;
                end
            end
            SWAP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                r_shadow[i] <= identity_entry(i, FRAC_BITS);
                r_active[i] <= identity_entry(i, FRAC_BITS);
            end
            r_cfg_err    <= 1'b0;
            r_swap_count <= '0;
        end else begin
            r_cfg_err <= w_cfg_accept & ~w_addr_ok;
            if (w_cfg_accept && w_addr_ok) begin
                r_shadow[cfg_addr] <= cfg_data;
            end
            if (r_state == SWAP) begin
                r_active     <= r_shadow;
                r_swap_count <= r_swap_count + SWAP_CNT_W'(1);
            end
        end
    end

    assign h11        = r_active[H11];
    assign h12        = r_active[H12];
    assign h13        = r_active[H13];
    assign h21        = r_active[H21];
    assign h22        = r_active[H22];
    assign h23        = r_active[H23];
    assign h31        = r_active[H31];
    assign h32        = r_active[H32];
    assign h33        = r_active[H33];
    assign cfg_err    = r_cfg_err;
    assign busy       = (r_state != IDLE);
    assign swap_count = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_keystone_coeff_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keystone_coeff_sequencer
//  Purpose  : Scoreboard bench for the keystone coefficient sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keystone_coeff_sequencer;
    import keystone_cfg_pkg::*;

    localparam int FRAC_BITS = 23;
    typedef logic [NUM_COEFFS*32-1:0] bank_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_commit, up_valid_in, up_sof_in;
    logic        ip_ready_in, ip_out_valid, ds_ready_in;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_ready, cfg_err, up_ready_out, ip_valid_out, busy;
    logic [31:0] h11, h12, h13, h21, h22, h23, h31, h32, h33;
    logic [15:0] swap_count;

    always #5 clock = ~clock;

    keystone_coeff_sequencer #(
        .FRAC_BITS(FRAC_BITS), .MAX_INFLIGHT(4095), .SWAP_CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
        .up_valid_in(up_valid_in), .up_sof_in(up_sof_in), .up_ready_out(up_ready_out),
        .ip_valid_out(ip_valid_out), .ip_ready_in(ip_ready_in),
        .ip_out_valid(ip_out_valid), .ds_ready_in(ds_ready_in),
        .h11(h11), .h12(h12), .h13(h13), .h21(h21), .h22(h22), .h23(h23),
        .h31(h31), .h32(h32), .h33(h33),
        .busy(busy), .swap_count(swap_count)
    );

    bank_t h_now;
    assign h_now = {h33, h32, h31, h23, h22, h21, h13, h12, h11};

    int          checks = 0;
    int          errors = 0;
    bank_t       exp_q[$];
    logic [31:0] model_shadow [NUM_COEFFS];
    int          model_inflight = 0;
    bank_t       prev_h;
    logic [15:0] prev_swaps = '0;
    logic        prev_reset = 1'b1;

    function automatic bank_t identity_bank();
        bank_t b = '0;
        for (int i = 0; i < NUM_COEFFS; i++)
            if (i / 3 == i % 3) b[i*32 +: 32] = 32'd1 << FRAC_BITS;
        return b;
    endfunction

    function automatic bank_t shadow_bank();
        bank_t b = '0;
        for (int i = 0; i < NUM_COEFFS; i++) b[i*32 +: 32] = model_shadow[i];
        return b;
    endfunction

    task automatic check(input string name, input bank_t act, input bank_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event expected normal progress", name);
    endtask

    // Monitor: pops expected banks on every swap, checks stability and beat conservation,
    // and tracks pipeline occupancy as the IP would see it.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < NUM_COEFFS; i++) model_shadow[i] = (i / 3 == i % 3) ? (32'd1 << FRAC_BITS) : 32'd0;
            model_inflight = 0;
            prev_reset     = 1'b1;
        end else begin
            if (prev_reset) begin
                check("post_reset_coeffs", h_now, identity_bank());
                check("post_reset_swaps", bank_t'(swap_count), bank_t'(0));
            end else if (swap_count != prev_swaps) begin
                check("swap_increment", bank_t'(swap_count), bank_t'(prev_swaps + 16'd1));
                if (exp_q.size() == 0) fail_now("unexpected_swap");
                else check("swap_bank", h_now, exp_q.pop_front());
            end else begin
                check("coeff_stable", h_now, prev_h);
            end
            prev_reset = 1'b0;
            check("beat_conservation", bank_t'(up_valid_in & up_ready_out),
                  bank_t'(ip_valid_out & ip_ready_in));
            if (ip_valid_out && ip_ready_in) model_inflight++;
            if (ip_out_valid && ds_ready_in && model_inflight > 0) model_inflight--;
        end
        prev_h     = h_now;
        prev_swaps = swap_count;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic cfg_op(input logic valid, input logic [3:0] addr, input logic [31:0] data,
                          input logic commit);
        step();
        cfg_valid = valid; cfg_addr = addr; cfg_data = data; cfg_commit = commit;
        sample();
        check("cfg_ready_idle", bank_t'(cfg_ready), bank_t'(1));
        if (valid && addr <= 4'd8) model_shadow[addr] = data;
        if (commit) exp_q.push_back(shadow_bank());
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        sample();
        check("cfg_err", bank_t'(cfg_err), bank_t'(valid && addr > 4'd8));
    endtask

    task automatic drain_pipe();
        int n = 0;
        step();
        up_valid_in = 1'b0; up_sof_in = 1'b0; ip_out_valid = 1'b1; ds_ready_in = 1'b1;
        sample();
        while (model_inflight != 0 && n < 200) begin
            step(); sample(); n++;
        end
        if (model_inflight != 0) fail_now("drain_timeout");
        step();
        ip_out_valid = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            up_valid_in = 1'b1; up_sof_in = 1'b0; ip_ready_in = 1'b1; ip_out_valid = 1'b0;
            sample();
            check("beat_forwarded", bank_t'(ip_valid_out), bank_t'(1));
        end
        step();
        up_valid_in = 1'b0;
    endtask

    task automatic random_traffic(input int n, input logic armed);
        for (int i = 0; i < n; i++) begin
            step();
            up_valid_in  = 1'($urandom_range(0, 1));
            up_sof_in    = 1'b0;
            ip_ready_in  = 1'($urandom_range(0, 1));
            ip_out_valid = 1'($urandom_range(0, 1));
            ds_ready_in  = 1'($urandom_range(0, 1));
            sample();
            check("pass_valid", bank_t'(ip_valid_out), bank_t'(up_valid_in));
            check("pass_ready", bank_t'(up_ready_out), bank_t'(ip_ready_in));
            if (armed) begin
                check("armed_busy", bank_t'(busy), bank_t'(1));
                check("armed_cfg_ready", bank_t'(cfg_ready), bank_t'(0));
            end
        end
    endtask

    // Present SOF while ARMED; output side stalls for `stall` cycles then drains randomly.
    // Returns the number of cycles from SOF presentation to the swap becoming visible.
    task automatic frame_swap(input int stall, output int seen_at);
        int          zero_at = -1;
        logic [15:0] start   = swap_count;
        seen_at = -1;
        step();
        up_valid_in = 1'b1; up_sof_in = 1'b1; ip_ready_in = 1'b1;
        ip_out_valid = 1'b0; ds_ready_in = 1'b1;
        sample();
        check("sof_gated_valid", bank_t'(ip_valid_out), bank_t'(0));
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) sample();
            if (swap_count != start) begin
                seen_at = i;
                break;
            end
            check("stall_upstream", bank_t'(up_ready_out), bank_t'(0));
            if (zero_at < 0 && model_inflight == 0) zero_at = i;
            step();
            ip_out_valid = (i + 1 >= stall) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (seen_at < 0) begin
            fail_now("swap_timeout");
        end else begin
            check("swap_latency", bank_t'(seen_at), bank_t'(zero_at + 3));
            check("sof_released_valid", bank_t'(ip_valid_out), bank_t'(1));
            check("sof_released_ready", bank_t'(up_ready_out), bank_t'(1));
        end
        step();
        up_valid_in = 1'b0; up_sof_in = 1'b0; ip_out_valid = 1'b0;
    endtask

    int lat;

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
        up_valid_in = 1'b0; up_sof_in = 1'b0; ip_ready_in = 1'b1;
        ip_out_valid = 1'b0; ds_ready_in = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        sample();
        check("reset_coeffs", h_now, identity_bank());
        check("reset_busy", bank_t'(busy), bank_t'(0));
        check("reset_swaps", bank_t'(swap_count), bank_t'(0));
        check("reset_cfg_ready", bank_t'(cfg_ready), bank_t'(1));

        // Pending commit with no SOF: coefficients hold, stream passes.
        cfg_op(1'b1, 4'd2, 32'd2, 1'b0);
        cfg_op(1'b1, 4'd7, 32'd608, 1'b0);
        cfg_op(1'b0, 4'd0, 32'd0, 1'b1);
        random_traffic(50, 1'b1);
        check("h13_held", bank_t'(h13), bank_t'(0));
        step();
        cfg_valid = 1'b1; cfg_addr = 4'd1; cfg_data = 32'hDEAD_BEEF; cfg_commit = 1'b1;
        sample();
        check("armed_rejects_cfg", bank_t'(cfg_ready), bank_t'(0));
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;

        // Five stalled beats then SOF: upstream blocked until drained.
        drain_pipe();
        send_beats(5);
        frame_swap(4, lat);
        check("first_swap_h13", bank_t'(h13), bank_t'(2));
        check("first_swap_h32", bank_t'(h32), bank_t'(608));

        // Bad address, then write+commit in the same cycle.
        cfg_op(1'b1, 4'd12, 32'hBAD0_0001, 1'b0);
        sample();
        check("cfg_err_one_cycle", bank_t'(cfg_err), bank_t'(0));
        cfg_op(1'b1, 4'd0, 32'h0123_4567, 1'b1);
        drain_pipe();
        frame_swap(0, lat);
        check("empty_drain_latency", bank_t'(lat), bank_t'(3));

        // Simultaneous in/out handshakes leave occupancy unchanged.
        drain_pipe();
        send_beats(3);
        step();
        up_valid_in = 1'b1; up_sof_in = 1'b0; ip_ready_in = 1'b1; ip_out_valid = 1'b1; ds_ready_in = 1'b1;
        repeat (10) step();
        up_valid_in = 1'b0; ip_out_valid = 1'b0;
        cfg_op(1'b1, 4'd8, 32'h0000_5555, 1'b1);
        frame_swap(5, lat);

        for (int r = 0; r < 4; r++) begin
            random_traffic(10, 1'b0);
            for (int w = 0; w < 3; w++)
                cfg_op(1'b1, 4'($urandom_range(0, 11)), $urandom, 1'b0);
            cfg_op(1'b0, 4'd0, 32'd0, 1'b1);
            random_traffic(20, 1'b1);
            frame_swap(int'($urandom_range(0, 6)), lat);
        end

        // Reset while draining discards the pending swap and shadow edits.
        cfg_op(1'b1, 4'd4, 32'd77, 1'b1);
        send_beats(2);
        step();
        up_valid_in = 1'b1; up_sof_in = 1'b1; ip_out_valid = 1'b0;
        sample();
        step();
        sample();
        check("drain_busy", bank_t'(busy), bank_t'(1));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; ip_ready_in = 1'b0;
        sample();
        check("rst_busy", bank_t'(busy), bank_t'(0));
        check("rst_cfg_ready", bank_t'(cfg_ready), bank_t'(1));
        check("rst_ready_low", bank_t'(up_ready_out), bank_t'(0));
        check("rst_sof_forward", bank_t'(ip_valid_out), bank_t'(1));
        step();
        ip_ready_in = 1'b1;
        sample();
        check("rst_ready_high", bank_t'(up_ready_out), bank_t'(1));
        step();
        up_valid_in = 1'b0; up_sof_in = 1'b0;

        // Commit right after reset must apply the identity shadow.
        cfg_op(1'b0, 4'd0, 32'd0, 1'b1);
        drain_pipe();
        frame_swap(0, lat);
        check("post_reset_swap_count", bank_t'(swap_count), bank_t'(1));
        check("queue_empty", bank_t'(exp_q.size()), bank_t'(0));

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
